decode_issue_buffer: RTL and testbench

DECODE_ISSUE_BUFFER -- requirements
Module: decode_issue_buffer

---
 rtl/decode_issue_buffer.sv | 94 +++++++++
 tb/tb_decode_issue_buffer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_buffer.sv
// Decode issue buffer: pops up to two instruction-queue entries into a registered
// issue group, keeping a branch and its delay slot together.
module decode_issue_buffer #(
    parameter  int PERF_WIDTH = 32,
    // entry layout: [65] valid, [64] iaddr_ex, [63:32] pc, [31:0] instr
    localparam int ENTRY_W    = 66
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    issue_stall,
    input  logic [1:0][ENTRY_W-1:0] fetch_entry,
    output logic [1:0]              fetch_ack,
    output logic [1:0][ENTRY_W-1:0] issue_entry,
    output logic [1:0]              issue_valid,
    output logic [1:0]              issue_is_cf,
    output logic [PERF_WIDTH-1:0]   perf_ds_wait
);

    function automatic logic is_cf(input logic [ENTRY_W-1:0] e);
        logic [5:0] op;
        logic [5:0] fn;
        op = e[31:26];
        fn = e[5:0];
        // an entry with a fetch exception never redirects, whatever it decodes as
        return !e[64] &&
               (op == 6'b000010 || op == 6'b000011 || op == 6'b000001 ||
                op[5:2] == 4'b0001 || op[5:2] == 4'b0101 ||
                (op == 6'b000000 && (fn == 6'b001000 || fn == 6'b001001)));
    endfunction

    logic [1:0][ENTRY_W-1:0] entry_d, entry_q;
    logic [1:0]              valid_d, valid_q;
    logic [1:0]              cf_d, cf_q;
    logic [PERF_WIDTH-1:0]   perf_d, perf_q;

    logic v0, v1, cf0, cf1, accept, ds_wait;

    always_comb begin
        v0      = fetch_entry[0][65];
        v1      = v0 & fetch_entry[1][65];
        cf0     = is_cf(fetch_entry[0]);
        cf1     = is_cf(fetch_entry[1]);
        accept  = (valid_q == 2'b00 || !issue_stall) && !flush && !rst;
        fetch_ack = 2'd0;
        ds_wait   = 1'b0;
        if (accept && v0) begin
            if (cf0) begin
                if (v1) fetch_ack = 2'd2;
                else    ds_wait   = 1'b1;
            end else if (v1 && !cf1) begin
                fetch_ack = 2'd2;
            end else begin
                fetch_ack = 2'd1;
            end
        end
    end

    always_comb begin
        entry_d = entry_q;
        valid_d = valid_q;
        cf_d    = cf_q;
        perf_d  = perf_q + PERF_WIDTH'(ds_wait);
        if (rst) begin
            entry_d = '0;
            valid_d = '0;
            cf_d    = '0;
            perf_d  = '0;
        end else if (flush) begin
            entry_d = '0;
            valid_d = '0;
            cf_d    = '0;
        end else if (accept) begin
            for (int i = 0; i < 2; i++) begin
                valid_d[i] = (int'(fetch_ack) > i);
                entry_d[i] = valid_d[i] ? fetch_entry[i] : '0;
                cf_d[i]    = valid_d[i] & is_cf(fetch_entry[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        entry_q <= entry_d;
        valid_q <= valid_d;
        cf_q    <= cf_d;
        perf_q  <= perf_d;
    end

    assign issue_entry  = entry_q;
    assign issue_valid  = valid_q;
    assign issue_is_cf  = cf_q;
    assign perf_ds_wait = perf_q;

endmodule

// File: tb/tb_decode_issue_buffer.sv
// Bench for decode_issue_buffer: directed scenarios plus randomized traffic
// against a transaction-level model of the issue group and wait counter.
module tb_decode_issue_buffer;

    localparam logic [31:0] ADDU = 32'h00851021;
    localparam logic [31:0] LW   = 32'h8C820000;
    localparam logic [31:0] BEQ  = 32'h10850004;
    localparam logic [31:0] NOP  = 32'h00000000;
    localparam logic [31:0] JR   = 32'h03E00008;
    localparam logic [31:0] J    = 32'h08000000;

    logic              clk = 1'b0;
    logic              rst, flush, issue_stall;
    logic [1:0][65:0]  fetch_entry;
    logic [1:0]        fetch_ack, fetch_ack_s;
    logic [1:0][65:0]  issue_entry, issue_entry_s;
    logic [1:0]        issue_valid, issue_valid_s, issue_is_cf, issue_is_cf_s;
    logic [31:0]       perf_ds_wait;
    logic [3:0]        perf_ds_wait_s;

    int checks = 0;
    int failures = 0;

    // model of the expected issue group
    logic [1:0]       m_valid, m_cf;
    logic [1:0][65:0] m_ent;
    logic [31:0]      m_perf;
    logic [3:0]       m_perf4;

    always #5 clk = ~clk;

    decode_issue_buffer dut (
        .clk(clk), .rst(rst), .flush(flush), .issue_stall(issue_stall),
        .fetch_entry(fetch_entry), .fetch_ack(fetch_ack), .issue_entry(issue_entry),
        .issue_valid(issue_valid), .issue_is_cf(issue_is_cf), .perf_ds_wait(perf_ds_wait)
    );

    // narrow counter instance so wrap-around is reachable quickly
    decode_issue_buffer #(.PERF_WIDTH(4)) dut_s (
        .clk(clk), .rst(rst), .flush(flush), .issue_stall(issue_stall),
        .fetch_entry(fetch_entry), .fetch_ack(fetch_ack_s), .issue_entry(issue_entry_s),
        .issue_valid(issue_valid_s), .issue_is_cf(issue_is_cf_s), .perf_ds_wait(perf_ds_wait_s)
    );

    function automatic logic [65:0] mk(input bit v, input bit ex, input logic [31:0] instr);
        logic [31:0] pc;
        pc = $urandom & 32'hFFFF_FFFC;
        return {v, ex, pc, instr};
    endfunction

    function automatic bit ref_cf(input logic [65:0] e);
        logic [5:0] op;
        op = e[31:26];
        if (e[64]) return 0;
        if (op inside {6'h01, 6'h02, 6'h03, [6'h04:6'h07], [6'h14:6'h17]}) return 1;
        return op == 6'h00 && e[5:0] inside {6'h08, 6'h09};
    endfunction

    function automatic bit ref_accept();
        return !rst && !flush && (m_valid == 2'b00 || !issue_stall);
    endfunction

    function automatic int exp_ack();
        bit h0, h1;
        h0 = fetch_entry[0][65];
        h1 = h0 && fetch_entry[1][65];
        if (!ref_accept() || !h0) return 0;
        if (ref_cf(fetch_entry[0])) return h1 ? 2 : 0;
        if (!h1) return 1;
        return ref_cf(fetch_entry[1]) ? 1 : 2;
    endfunction

    task automatic set_in(input logic [65:0] e0, input logic [65:0] e1);
        fetch_entry[0] = e0;
        fetch_entry[1] = e1;
        #1;
    endtask

    // one clock: advance the model with the inputs currently applied
    task automatic step();
        int  n;
        bit  acc, waiting;
        n       = exp_ack();
        acc     = ref_accept();
        waiting = acc && fetch_entry[0][65] && ref_cf(fetch_entry[0]) && !fetch_entry[1][65];
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_cf = 0; m_ent = '0; m_perf = 0; m_perf4 = 0;
        end else if (flush) begin
            m_valid = 0; m_cf = 0; m_ent = '0;
        end else if (acc) begin
            for (int i = 0; i < 2; i++) begin
                m_valid[i] = (i < n);
                m_ent[i]   = (i < n) ? fetch_entry[i] : '0;
                m_cf[i]    = (i < n) && ref_cf(fetch_entry[i]);
            end
            if (waiting) begin
                m_perf  = m_perf + 1;
                m_perf4 = m_perf4 + 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; flush = 0; issue_stall = 0;
        set_in(mk(1, 0, ADDU), mk(1, 0, LW));
        checks++;
        if (fetch_ack !== 2'd0) begin failures++; $display("FAIL reset_ack got=%0d exp=0", fetch_ack); end
        step(); step();
        checks++;
        if (issue_valid !== 2'b00 || issue_is_cf !== 2'b00 || issue_entry !== '0 || perf_ds_wait !== 32'd0) begin
            failures++;
            $display("FAIL reset_state got v=%b cf=%b perf=%0d exp v=00 cf=00 perf=0", issue_valid, issue_is_cf, perf_ds_wait);
        end
        rst = 0;
    endtask

    task automatic test_dual_alu();
        set_in(mk(1, 0, ADDU), mk(1, 0, LW));
        checks++;
        if (fetch_ack !== 2'd2) begin failures++; $display("FAIL dual_alu_ack got=%0d exp=2", fetch_ack); end
        step();
        checks++;
        if (issue_valid !== 2'b11 || issue_is_cf !== 2'b00 || issue_entry !== m_ent) begin
            failures++; $display("FAIL dual_alu_issue got v=%b cf=%b exp v=11 cf=00", issue_valid, issue_is_cf);
        end
    endtask

    task automatic test_branch_split();
        set_in(mk(1, 0, ADDU), mk(1, 0, BEQ));
        checks++;
        if (fetch_ack !== 2'd1) begin failures++; $display("FAIL split_ack got=%0d exp=1", fetch_ack); end
        step();
        checks++;
        if (issue_valid !== 2'b01) begin failures++; $display("FAIL split_issue got v=%b exp=01", issue_valid); end
        set_in(mk(1, 0, BEQ), mk(1, 0, NOP));
        checks++;
        if (fetch_ack !== 2'd2) begin failures++; $display("FAIL pair_ack got=%0d exp=2", fetch_ack); end
        step();
        checks++;
        if (issue_valid !== 2'b11 || issue_is_cf !== 2'b01) begin
            failures++; $display("FAIL pair_issue got v=%b cf=%b exp v=11 cf=01", issue_valid, issue_is_cf);
        end
    endtask

    task automatic test_ds_wait();
        set_in(mk(1, 0, JR), mk(0, 0, NOP));
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (fetch_ack !== 2'd0) begin failures++; $display("FAIL ds_wait_ack cyc=%0d got=%0d exp=0", c, fetch_ack); end
            step();
        end
        checks++;
        if (perf_ds_wait !== 32'd3 || issue_valid !== 2'b00) begin
            failures++; $display("FAIL ds_wait_perf got perf=%0d v=%b exp perf=3 v=00", perf_ds_wait, issue_valid);
        end
        set_in(mk(1, 0, JR), mk(1, 0, NOP));
        checks++;
        if (fetch_ack !== 2'd2) begin failures++; $display("FAIL ds_arrive_ack got=%0d exp=2", fetch_ack); end
        step();
    endtask

    task automatic test_stall();
        logic [1:0][65:0] held;
        issue_stall = 0;
        set_in(mk(1, 0, ADDU), mk(1, 0, LW));
        step();
        held = issue_entry;
        issue_stall = 1;
        set_in(mk(1, 0, LW), mk(1, 0, ADDU));
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (fetch_ack !== 2'd0) begin failures++; $display("FAIL stall_ack cyc=%0d got=%0d exp=0", c, fetch_ack); end
            step();
            checks++;
            if (issue_entry !== held || issue_valid !== 2'b11 || issue_is_cf !== 2'b00) begin
                failures++; $display("FAIL stall_hold cyc=%0d got v=%b cf=%b exp v=11 cf=00", c, issue_valid, issue_is_cf);
            end
        end
        issue_stall = 0;
        #1;
        checks++;
        if (fetch_ack !== 2'd2) begin failures++; $display("FAIL unstall_ack got=%0d exp=2", fetch_ack); end
        step();
        checks++;
        if (issue_entry !== m_ent || issue_entry[0][31:0] !== LW) begin
            failures++; $display("FAIL unstall_issue got=%h exp=%h", issue_entry[0][31:0], LW);
        end
    endtask

    task automatic test_flush();
        issue_stall = 1; flush = 1;
        set_in(mk(1, 0, ADDU), mk(1, 0, ADDU));
        checks++;
        if (fetch_ack !== 2'd0) begin failures++; $display("FAIL flush_ack got=%0d exp=0", fetch_ack); end
        step();
        checks++;
        if (issue_valid !== 2'b00 || issue_is_cf !== 2'b00) begin
            failures++; $display("FAIL flush_clear got v=%b cf=%b exp v=00 cf=00", issue_valid, issue_is_cf);
        end
        flush = 0; issue_stall = 0;
    endtask

    task automatic test_reset_mid_stall();
        set_in(mk(1, 0, ADDU), mk(1, 0, LW));
        step();
        issue_stall = 1; rst = 1;
        #1;
        step();
        checks++;
        if (issue_valid !== 2'b00 || issue_entry !== '0 || perf_ds_wait !== 32'd0) begin
            failures++; $display("FAIL reset_stall got v=%b perf=%0d exp v=00 perf=0", issue_valid, perf_ds_wait);
        end
        rst = 0; issue_stall = 0;
    endtask

    task automatic test_exc_wrap();
        set_in(mk(1, 1, J), mk(0, 0, NOP));
        checks++;
        if (fetch_ack !== 2'd1) begin failures++; $display("FAIL exc_ack got=%0d exp=1", fetch_ack); end
        step();
        checks++;
        if (issue_valid !== 2'b01 || issue_is_cf !== 2'b00) begin
            failures++; $display("FAIL exc_issue got v=%b cf=%b exp v=01 cf=00", issue_valid, issue_is_cf);
        end
        set_in(mk(1, 0, JR), mk(0, 0, NOP));
        for (int c = 0; c < 15; c++) step();
        checks++;
        if (perf_ds_wait_s !== 4'hF) begin failures++; $display("FAIL wrap_pre got=%0d exp=15", perf_ds_wait_s); end
        flush = 1; #1; step(); flush = 0; #1;
        checks++;
        if (perf_ds_wait_s !== 4'hF) begin failures++; $display("FAIL flush_keeps_perf got=%0d exp=15", perf_ds_wait_s); end
        step();
        checks++;
        if (perf_ds_wait_s !== 4'h0 || perf_ds_wait !== 32'd16) begin
            failures++; $display("FAIL wrap got narrow=%0d wide=%0d exp narrow=0 wide=16", perf_ds_wait_s, perf_ds_wait);
        end
    endtask

    task automatic test_random();
        logic [31:0] pal [8];
        pal = '{ADDU, LW, BEQ, NOP, JR, J, 32'h0C000010, 32'h04010003};
        for (int c = 0; c < 400; c++) begin
            rst         = ($urandom_range(0, 99) < 2);
            flush       = ($urandom_range(0, 99) < 5);
            issue_stall = ($urandom_range(0, 99) < 30);
            set_in(mk($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0, pal[$urandom_range(0, 7)]),
                   mk($urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0, pal[$urandom_range(0, 7)]));
            checks++;
            if (fetch_ack !== 2'(exp_ack()) || fetch_ack_s !== fetch_ack) begin
                failures++; $display("FAIL rand_ack cyc=%0d got=%0d exp=%0d", c, fetch_ack, exp_ack());
            end
            step();
            checks++;
            if (issue_valid !== m_valid || issue_is_cf !== m_cf || issue_entry !== m_ent ||
                perf_ds_wait !== m_perf || perf_ds_wait_s !== m_perf4) begin
                failures++;
                $display("FAIL rand_state cyc=%0d got v=%b cf=%b perf=%0d/%0d exp v=%b cf=%b perf=%0d/%0d",
                         c, issue_valid, issue_is_cf, perf_ds_wait, perf_ds_wait_s, m_valid, m_cf, m_perf, m_perf4);
            end
        end
        rst = 0; flush = 0; issue_stall = 0;
    endtask

    initial begin
        m_valid = 0; m_cf = 0; m_ent = '0; m_perf = 0; m_perf4 = 0;
        test_reset();
        test_dual_alu();
        test_branch_split();
        test_ds_wait();
        test_stall();
        test_flush();
        test_reset_mid_stall();
        test_exc_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
